shift_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle 32-bit barrel shifter in the ALU path.
- Logarithmic shifter, WIDTH bits wide, with logical and arithmetic shifts, rotates (optional), defined flags and a valid/ready handshake.
- Register stages are inserted between mux levels so it fits multi-cycle and pipelined CPU datapaths.
- Sits between the register-file operand latch and the ALU result mux; drives Y_lo and the C/V/N/Z flags.

---
 rtl/shift_defs.sv | 31 +++
 rtl/shift_level.sv | 52 +++++
 rtl/shift_pipe.sv | 169 ++++++++++++++++
 tb/tb_shift_pipe.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_defs.sv
// rtl/shift_defs.sv - shift type codes, flag bit order and helpers for shift_pipe (rotates under SHIFT_ROTATE_EN)
package shift_defs;

    localparam logic [4:0] SLL = 5'h0C;
    localparam logic [4:0] SRL = 5'h0D;
    localparam logic [4:0] SRA = 5'h0E;
    localparam logic [4:0] ROR = 5'h10;
    localparam logic [4:0] ROL = 5'h11;

    // Bit positions of the packed {N,Z,C,V} flag word seen by the ALU flag mux
    localparam int unsigned FLAG_V = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic logic is_legal(input logic [4:0] t);
`ifdef SHIFT_ROTATE_EN
        return t inside {SLL, SRL, SRA, ROR, ROL};
`else
        return t inside {SLL, SRL, SRA};
`endif
    endfunction

endpackage

// File: rtl/shift_level.sv
// rtl/shift_level.sv - one mux level of the log shifter; rotate paths only with SHIFT_ROTATE_EN
module shift_level
    import shift_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] d,
    input  logic [4:0]       stype,
    input  logic             en,
    input  logic             ci,
    output logic [WIDTH-1:0] q,
    output logic             co
);

    // Shift by DIST when enabled; carry is the last bit moved out, so the last enabled level wins
    always_comb begin
        q  = d;
        co = ci;
        if (en) begin
            case (stype)
                SLL: begin
                    q  = d << DIST;
                    co = d[WIDTH-DIST];
                end
                SRL: begin
                    q  = d >> DIST;
                    co = d[DIST-1];
                end
                SRA: begin
                    q  = $unsigned($signed(d) >>> DIST);
                    co = d[DIST-1];
                end
`ifdef SHIFT_ROTATE_EN
                ROR: begin
                    q  = {d[DIST-1:0], d[WIDTH-1:DIST]};
                    co = d[DIST-1];
                end
                ROL: begin
                    q  = {d[WIDTH-DIST-1:0], d[WIDTH-1:WIDTH-DIST]};
                    co = d[WIDTH-DIST];
                end
`endif
                default: begin
                    q  = d;
                    co = ci;
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - pipelined logarithmic shifter with handshake and flags; rotates with SHIFT_ROTATE_EN
module shift_pipe
    import shift_defs::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int STAGES = 2,
    localparam int SAW    = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] T,
    input  logic [SAW-1:0]   shamt,
    input  logic [4:0]       stype,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y_lo,
    output logic             C,
    output logic             V,
    output logic             N,
    output logic             Z,
    output logic             illegal
);

    // First mux level owned by stage k; earlier stages absorb the remainder levels
    function automatic int lv_first(input int k);
        int base;
        int ext;
        base = SAW / STAGES;
        ext  = SAW % STAGES;
        return k * base + ((k < ext) ? k : ext);
    endfunction

    function automatic int stage_of(input int lvl);
        int s;
        s = 0;
        for (int k = 0; k < STAGES; k++) begin
            if (lvl >= lv_first(k)) s = k;
        end
        return s;
    endfunction

    logic [STAGES-1:0] st_v;
    logic [WIDTH-1:0]  st_d  [STAGES];
    logic              st_c  [STAGES];
    logic [4:0]        st_t  [STAGES];
    logic [SAW-1:0]    st_sh [STAGES];
    logic [3:0]        flags_q;
    logic              ill_q;

    logic [STAGES-1:0] sin_v;
    logic [STAGES-1:0] sin_c;
    logic [STAGES-1:0] sout_c;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  sin_d  [STAGES];
    logic [WIDTH-1:0]  sout_d [STAGES];
    logic [4:0]        sin_t  [STAGES];
    logic [SAW-1:0]    sin_sh [STAGES];

    logic [WIDTH-1:0]  lo_d [SAW];
    logic [SAW-1:0]    lo_c;

    logic [3:0]        flags_n;
    logic              rdy_chain;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LAST = lv_first(k + 1) - 1;
        if (k == 0) begin : g_in
            assign sin_v[k]  = in_valid;
            assign sin_d[k]  = T;
            assign sin_c[k]  = 1'b0;
            assign sin_t[k]  = stype;
            assign sin_sh[k] = shamt;
        end else begin : g_fwd
            assign sin_v[k]  = st_v[k-1];
            assign sin_d[k]  = st_d[k-1];
            assign sin_c[k]  = st_c[k-1];
            assign sin_t[k]  = st_t[k-1];
            assign sin_sh[k] = st_sh[k-1];
        end
        assign sout_d[k] = lo_d[LAST];
        assign sout_c[k] = lo_c[LAST];
    end

    for (genvar i = 0; i < SAW; i++) begin : g_lvl
        localparam int K = stage_of(i);
        logic [WIDTH-1:0] d_in;
        logic             c_in;
        if (i == lv_first(K)) begin : g_head
            assign d_in = sin_d[K];
            assign c_in = sin_c[K];
        end else begin : g_chain
            assign d_in = lo_d[i-1];
            assign c_in = lo_c[i-1];
        end
        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << i)
        ) u_level (
            .d     (d_in),
            .stype (sin_t[K]),
            .en    (sin_sh[K][i]),
            .ci    (c_in),
            .q     (lo_d[i]),
            .co    (lo_c[i])
        );
    end

    // A stage loads when empty or when its contents move on this cycle; ready ripples back from the consumer
    always_comb begin
        load      = '0;
        rdy_chain = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            load[k]   = !st_v[k] || rdy_chain;
            rdy_chain = load[k];
        end
    end

    // Flags for the result entering the output stage, registered so they hold during a stall
    always_comb begin
        flags_n         = '0;
        flags_n[FLAG_N] = sout_d[STAGES-1][WIDTH-1];
        flags_n[FLAG_Z] = (sout_d[STAGES-1] == '0);
        flags_n[FLAG_C] = sout_c[STAGES-1];
        flags_n[FLAG_V] = 1'b0;
    end

    // Stage registers; payload only updates on a real item so idle outputs stay put
    always_ff @(posedge clk) begin
        if (reset) begin
            st_v    <= '0;
            flags_q <= '0;
            ill_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                st_d[k]  <= '0;
                st_c[k]  <= 1'b0;
                st_t[k]  <= '0;
                st_sh[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    st_v[k] <= sin_v[k];
                    if (sin_v[k]) begin
                        st_d[k]  <= sout_d[k];
                        st_c[k]  <= sout_c[k];
                        st_t[k]  <= sin_t[k];
                        st_sh[k] <= sin_sh[k];
                    end
                end
            end
            if (load[STAGES-1] && sin_v[STAGES-1]) begin
                flags_q <= flags_n;
                ill_q   <= !is_legal(sin_t[STAGES-1]);
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = st_v[STAGES-1];
    assign Y_lo      = st_d[STAGES-1];
    assign C         = flags_q[FLAG_C];
    assign V         = flags_q[FLAG_V];
    assign N         = flags_q[FLAG_N];
    assign Z         = flags_q[FLAG_Z];
    assign illegal   = ill_q;

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - self-checking bench for shift_pipe (32x2 and 64x6; rotate cases follow SHIFT_ROTATE_EN)
module tb_shift_pipe;

    localparam logic [4:0] C_SLL = 5'h0C;
    localparam logic [4:0] C_SRL = 5'h0D;
    localparam logic [4:0] C_SRA = 5'h0E;
    localparam logic [4:0] C_ROR = 5'h10;
    localparam logic [4:0] C_ROL = 5'h11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] T, Y_lo;
    logic [4:0]  shamt, stype;
    logic        C, V, N, Z, illegal;

    logic        in_valid64, in_ready64, out_valid64, out_ready64;
    logic [63:0] T64, Y64;
    logic [5:0]  shamt64;
    logic [4:0]  stype64;
    logic        C64, V64, N64, Z64, ill64;

    shift_pipe #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .T(T), .shamt(shamt), .stype(stype), .out_valid(out_valid), .out_ready(out_ready),
        .Y_lo(Y_lo), .C(C), .V(V), .N(N), .Z(Z), .illegal(illegal)
    );

    shift_pipe #(.WIDTH(64), .STAGES(6)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64),
        .T(T64), .shamt(shamt64), .stype(stype64), .out_valid(out_valid64), .out_ready(out_ready64),
        .Y_lo(Y64), .C(C64), .V(V64), .N(N64), .Z(Z64), .illegal(ill64)
    );

    typedef struct {
        logic [31:0] y;
        logic        c;
        logic        n;
        logic        z;
        logic        ill;
        int          cyc;
        bit          lat;
    } exp_t;

    typedef struct {
        logic [4:0]  st;
        logic [31:0] t;
        logic [4:0]  sh;
        logic [31:0] y;
        logic        c;
        logic        ill;
    } vec_t;

    exp_t sb[$];
    exp_t cur_exp;
    exp_t mon_e;
    vec_t tbl[14];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   acc_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [31:0] y, input logic c, input logic ill, input bit lat);
        exp_t e;
        e.y = y; e.c = c; e.ill = ill; e.lat = lat; e.cyc = 0;
        e.n = y[31];
        e.z = (y == 32'h0);
        return e;
    endfunction

    function automatic vec_t mkv(input logic [4:0] st, input logic [31:0] t, input logic [4:0] sh,
                                 input logic [31:0] y, input logic c, input logic ill);
        vec_t v;
        v.st = st; v.t = t; v.sh = sh; v.y = y; v.c = c; v.ill = ill;
        return v;
    endfunction

    // Bit-by-bit reference for the random phase
    function automatic exp_t model(input logic [4:0] st, input logic [31:0] t, input logic [4:0] sh);
        logic [31:0] y;
        logic        c;
        logic        ill;
        int          s;
        s = int'(sh);
        y = t; c = 1'b0; ill = 1'b0;
        if (st == C_SLL) begin
            for (int i = 0; i < 32; i++) y[i] = (i >= s) ? t[i-s] : 1'b0;
            if (s != 0) c = t[32-s];
        end else if (st == C_SRL || st == C_SRA) begin
            for (int i = 0; i < 32; i++) y[i] = (i + s < 32) ? t[i+s] : ((st == C_SRA) ? t[31] : 1'b0);
            if (s != 0) c = t[s-1];
`ifdef SHIFT_ROTATE_EN
        end else if (st == C_ROR) begin
            for (int i = 0; i < 32; i++) y[i] = t[(i+s)%32];
            if (s != 0) c = y[31];
        end else if (st == C_ROL) begin
            for (int i = 0; i < 32; i++) y[i] = t[(i-s+32)%32];
            if (s != 0) c = y[0];
`endif
        end else begin
            ill = 1'b1;
        end
        return mk_exp(y, c, ill, 1'b0);
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got Y_lo=%h with nothing pending", Y_lo);
            end else begin
                mon_e = sb.pop_front();
                chk("y", Y_lo, mon_e.y);
                chk("c", C, mon_e.c);
                chk("v", V, 0);
                chk("n", N, mon_e.n);
                chk("z", Z, mon_e.z);
                chk("illegal", illegal, mon_e.ill);
                if (mon_e.lat) chk("latency", cycle - mon_e.cyc, 2);
            end
        end
        if (!reset && in_valid && in_ready) begin
            mon_e     = cur_exp;
            mon_e.cyc = cycle;
            sb.push_back(mon_e);
            acc_cnt++;
        end
    end

    task automatic send(input logic [4:0] st, input logic [31:0] t, input logic [4:0] sh, input exp_t e);
        bit ok;
        stype = st; T = t; shamt = sh; cur_exp = e; in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_accept", ok, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    bit          rdone;
    logic [31:0] hy;
    logic        hc, hn, hz, hi;
    bit          held;
    int          base, stale, start;
    bit          seen;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; T = '0; shamt = '0; stype = '0;
        in_valid64 = 1'b0; out_ready64 = 1'b1; T64 = '0; shamt64 = '0; stype64 = '0;
        cur_exp = mk_exp(32'h0, 1'b0, 1'b0, 1'b0);

        tbl[0]  = mkv(C_SRA, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, 1'b0);
        tbl[1]  = mkv(C_SLL, 32'h80000001, 5'd1,  32'h00000002, 1'b1, 1'b0);
        tbl[2]  = mkv(C_SRL, 32'h00000001, 5'd1,  32'h00000000, 1'b1, 1'b0);
        tbl[3]  = mkv(C_SLL, 32'h12345678, 5'd0,  32'h12345678, 1'b0, 1'b0);
        tbl[4]  = mkv(5'h1F, 32'h12345678, 5'd7,  32'h12345678, 1'b0, 1'b1);
`ifdef SHIFT_ROTATE_EN
        tbl[5]  = mkv(C_ROR, 32'h00000001, 5'd1,  32'h80000000, 1'b1, 1'b0);
        tbl[6]  = mkv(C_ROL, 32'h80000000, 5'd4,  32'h00000008, 1'b0, 1'b0);
`else
        tbl[5]  = mkv(C_ROR, 32'h00000001, 5'd1,  32'h00000001, 1'b0, 1'b1);
        tbl[6]  = mkv(C_ROL, 32'h80000000, 5'd4,  32'h80000000, 1'b0, 1'b1);
`endif
        tbl[7]  = mkv(C_SRA, 32'h7FFFFFFF, 5'd31, 32'h00000000, 1'b1, 1'b0);
        tbl[8]  = mkv(C_SLL, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0);
        tbl[9]  = mkv(C_SRL, 32'hFFFFFFFF, 5'd31, 32'h00000001, 1'b1, 1'b0);
        tbl[10] = mkv(C_SRA, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0, 1'b0);
        tbl[11] = mkv(C_SLL, 32'h0000FFFF, 5'd16, 32'hFFFF0000, 1'b0, 1'b0);
        tbl[12] = mkv(C_SRA, 32'h80000000, 5'd0,  32'h80000000, 1'b0, 1'b0);
        tbl[13] = mkv(5'h0F, 32'h000000A5, 5'd3,  32'h000000A5, 1'b0, 1'b1);

        // Reset values
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", Y_lo, 0);
        chk("rst_cvnz", {C, V, N, Z}, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid64", out_valid64, 0);
        chk("rst_y64", Y64, 0);

        // Table vectors, back-to-back, no backpressure
        @(posedge clk); #1;
        foreach (tbl[i]) send(tbl[i].st, tbl[i].t, tbl[i].sh, mk_exp(tbl[i].y, tbl[i].c, tbl[i].ill, 1'b1));
        drain();

        // Random vectors with random consumer stalls
        @(posedge clk); #1;
        rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [4:0]  st;
                    logic [31:0] t;
                    logic [4:0]  sh;
                    case ($urandom_range(0, 5))
                        0: st = C_SLL;
                        1: st = C_SRL;
                        2: st = C_SRA;
                        3: st = C_ROR;
                        4: st = C_ROL;
                        default: st = 5'($urandom());
                    endcase
                    t  = $urandom();
                    sh = 5'($urandom_range(0, 31));
                    send(st, t, sh, model(st, t, sh));
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Backpressure: 5 stalled cycles with 3 inputs offered
        @(posedge clk); #1;
        out_ready = 1'b0;
        base = acc_cnt;
        held = 1'b0;
        hy = '0; hc = 1'b0; hn = 1'b0; hz = 1'b0; hi = 1'b0;
        fork
            begin
                send(C_SRL, 32'h000000F0, 5'd4, mk_exp(32'h0000000F, 1'b0, 1'b0, 1'b0));
                send(C_SLL, 32'h00000001, 5'd3, mk_exp(32'h00000008, 1'b0, 1'b0, 1'b0));
                send(C_SRA, 32'h80000000, 5'd1, mk_exp(32'hC0000000, 1'b0, 1'b0, 1'b0));
            end
        join_none
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (out_valid) begin
                if (!held) begin
                    held = 1'b1;
                    hy = Y_lo; hc = C; hn = N; hz = Z; hi = illegal;
                end else begin
                    chk("stall_y", Y_lo, hy);
                    chk("stall_flags", {C, N, Z, illegal}, {hc, hn, hz, hi});
                end
            end
        end
        #1;
        chk("stall_out_valid", out_valid, 1);
        chk("accepts_when_full", acc_cnt - base, 2);
        chk("in_ready_full", in_ready, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("release_out_valid", out_valid, 1);
        end
        wait fork;
        drain();

        // Reset with two items in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        stype = C_SRA; T = 32'h80000000; shamt = 5'd1;
        cur_exp = mk_exp(32'hC0000000, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        stype = C_SLL; T = 32'h00000003; shamt = 5'd2;
        cur_exp = mk_exp(32'h0000000C, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        T = 32'h00000005;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b0;
        chk("inflight_before_reset", sb.size(), 2);
        sb.delete();
        @(negedge clk);
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_y", Y_lo, 0);
        chk("rst2_cvnz", {C, V, N, Z}, 0);
        chk("rst2_illegal", illegal, 0);
        chk("rst2_in_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("no_stale_output", stale, 0);

        // 64-bit, 6-stage: SRL by 63
        @(posedge clk); #1;
        stype64 = C_SRL; T64 = 64'h8000000000000000; shamt64 = 6'd63; in_valid64 = 1'b1;
        @(negedge clk);
        chk("w64_in_ready", in_ready64, 1);
        start = cycle;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid64) begin
                seen = 1'b1;
                break;
            end
        end
        chk("w64_out_seen", seen, 1);
        chk("w64_latency", cycle - start, 6);
        chk("w64_y", Y64, 64'h1);
        chk("w64_cvnz", {C64, V64, N64, Z64}, 0);
        chk("w64_illegal", ill64, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
